// File: rtl/cordic_fsm_pkg.sv
// Shared definitions for the CORDIC control FSM: the fixed state encoding and
// the variable-counter codes that pick the X/Y/Z register.
package cordic_fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT      = 4'd1,
        ST_LOAD_RB2  = 4'd2,
        ST_SHIFT_LUT = 4'd3,
        ST_BEGIN_ADD = 4'd4,
        ST_WAIT_ADD  = 4'd5,
        ST_NEXT_VAR  = 4'd6,
        ST_OUTPUT    = 4'd7,
        ST_DONE      = 4'd8
    } state_e;

    localparam logic [1:0] VAR_X = 2'b00;
    localparam logic [1:0] VAR_Y = 2'b01;
    localparam logic [1:0] VAR_Z = 2'b10;

endpackage

// File: rtl/cordic_fsm_ctrl.sv
// Control FSM for an iterative variable-serial CORDIC sin/cos datapath.
// Define CORDIC_FSM_STATE_DBG_EN to expose the state register on state_dbg.
module cordic_fsm_ctrl
    import cordic_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       beg_FSM_CORDIC,
    input  logic       ACK_FSM_CORDIC,
    input  logic       operation,
    input  logic [1:0] shift_region_flag,
    input  logic [1:0] cont_var,
    input  logic       ready_add_subt,
    input  logic       max_tick_iter,
    input  logic       min_tick_iter,
    input  logic       max_tick_var,
    input  logic       min_tick_var,
    output logic       reset_reg_cordic,
    output logic       ready_CORDIC,
    output logic       beg_add_subt,
    output logic       ack_add_subt,
    output logic       sel_mux_1,
    output logic       sel_mux_3,
    output logic [1:0] sel_mux_2,
    output logic       mode,
    output logic       enab_cont_iter,
    output logic       load_cont_iter,
    output logic       enab_cont_var,
    output logic       load_cont_var,
    output logic       enab_RB1,
    output logic       enab_RB2,
    output logic       enab_d_ff_Xn,
    output logic       enab_d_ff_Yn,
    output logic       enab_d_ff_Zn,
    output logic       enab_d_ff_out,
    output logic       enab_dff_shifted_x,
    output logic       enab_dff_shifted_y,
    output logic       enab_dff_LUT,
    output logic       enab_dff_sign
`ifdef CORDIC_FSM_STATE_DBG_EN
    ,
    output logic [3:0] state_dbg
`endif
);

    state_e state_q, state_d;

    // The variable counter's first-count flag has no role in sequencing.
    logic unused_min_tick_var;
    assign unused_min_tick_var = min_tick_var;

    assign mode      = 1'b0;
    assign sel_mux_3 = operation ^ (shift_region_flag[1] ^ shift_region_flag[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CORDIC_FSM_STATE_DBG_EN
    assign state_dbg = state_q;
`endif

    always_comb begin
        state_d            = state_q;
        reset_reg_cordic   = 1'b0;
        ready_CORDIC       = 1'b0;
        beg_add_subt       = 1'b0;
        ack_add_subt       = 1'b0;
        sel_mux_1          = 1'b0;
        sel_mux_2          = 2'b00;
        enab_cont_iter     = 1'b0;
        load_cont_iter     = 1'b0;
        enab_cont_var      = 1'b0;
        load_cont_var      = 1'b0;
        enab_RB1           = 1'b0;
        enab_RB2           = 1'b0;
        enab_d_ff_Xn       = 1'b0;
        enab_d_ff_Yn       = 1'b0;
        enab_d_ff_Zn       = 1'b0;
        enab_d_ff_out      = 1'b0;
        enab_dff_shifted_x = 1'b0;
        enab_dff_shifted_y = 1'b0;
        enab_dff_LUT       = 1'b0;
        enab_dff_sign      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beg_FSM_CORDIC) state_d = ST_INIT;
            end
            ST_INIT: begin
                reset_reg_cordic = 1'b1;
                enab_RB1         = 1'b1;
                load_cont_iter   = 1'b1;
                load_cont_var    = 1'b1;
                state_d          = ST_LOAD_RB2;
            end
            ST_LOAD_RB2: begin
                // First iteration feeds RB2 from the input angle, later ones from Z.
                enab_RB2  = 1'b1;
                sel_mux_1 = ~min_tick_iter;
                state_d   = ST_SHIFT_LUT;
            end
            ST_SHIFT_LUT: begin
                enab_dff_shifted_x = 1'b1;
                enab_dff_shifted_y = 1'b1;
                enab_dff_LUT       = 1'b1;
                enab_dff_sign      = 1'b1;
                state_d            = ST_BEGIN_ADD;
            end
            ST_BEGIN_ADD: begin
                beg_add_subt = 1'b1;
                sel_mux_2    = cont_var;
                state_d      = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
                sel_mux_2 = cont_var;
                if (ready_add_subt) begin
                    ack_add_subt = 1'b1;
                    enab_d_ff_Xn = (cont_var == VAR_X);
                    enab_d_ff_Yn = (cont_var == VAR_Y);
                    enab_d_ff_Zn = (cont_var == VAR_Z);
                    state_d      = ST_NEXT_VAR;
                end
            end
            ST_NEXT_VAR: begin
                enab_cont_var = 1'b1;
                if (!max_tick_var) begin
                    state_d = ST_BEGIN_ADD;
                end else if (!max_tick_iter) begin
                    enab_cont_iter = 1'b1;
                    state_d        = ST_LOAD_RB2;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                enab_d_ff_out = 1'b1;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                ready_CORDIC = 1'b1;
                if (ACK_FSM_CORDIC) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cordic_fsm_ctrl.sv
// Randomized bench for cordic_fsm_ctrl: a phase-level model predicts the full
// output word every cycle, and a directed walk-through pins the model itself.
module tb_cordic_fsm_ctrl;

    typedef struct {
        logic       rst;
        logic       beg;
        logic       ack;
        logic       op;
        logic [1:0] flag;
        logic [1:0] cv;
        logic       rdy;
        logic       mxi;
        logic       mni;
        logic       mxv;
        logic       mnv;
    } in_t;

    // Model phases, in the order the controller walks them.
    localparam int P_IDLE = 0, P_INIT = 1, P_LRB2 = 2, P_SHIFT = 3, P_BEG = 4,
                   P_WAIT = 5, P_NEXT = 6, P_OUT = 7, P_DONE = 8;

    logic clk = 1'b0;
    in_t  cur, nx;
    int   m_phase = P_IDLE;
    int   checks = 0;
    int   errors = 0;

    logic reset_reg_cordic, ready_CORDIC, beg_add_subt, ack_add_subt;
    logic sel_mux_1, sel_mux_3, mode;
    logic [1:0] sel_mux_2;
    logic enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var;
    logic enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_d_ff_out;
    logic enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign;
`ifdef CORDIC_FSM_STATE_DBG_EN
    logic [3:0] state_dbg;
`endif

    always #5 clk = ~clk;

    cordic_fsm_ctrl dut (
        .clk(clk), .reset(cur.rst), .beg_FSM_CORDIC(cur.beg), .ACK_FSM_CORDIC(cur.ack),
        .operation(cur.op), .shift_region_flag(cur.flag), .cont_var(cur.cv),
        .ready_add_subt(cur.rdy), .max_tick_iter(cur.mxi), .min_tick_iter(cur.mni),
        .max_tick_var(cur.mxv), .min_tick_var(cur.mnv),
        .reset_reg_cordic(reset_reg_cordic), .ready_CORDIC(ready_CORDIC),
        .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
        .sel_mux_1(sel_mux_1), .sel_mux_3(sel_mux_3), .sel_mux_2(sel_mux_2), .mode(mode),
        .enab_cont_iter(enab_cont_iter), .load_cont_iter(load_cont_iter),
        .enab_cont_var(enab_cont_var), .load_cont_var(load_cont_var),
        .enab_RB1(enab_RB1), .enab_RB2(enab_RB2),
        .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
        .enab_d_ff_out(enab_d_ff_out),
        .enab_dff_shifted_x(enab_dff_shifted_x), .enab_dff_shifted_y(enab_dff_shifted_y),
        .enab_dff_LUT(enab_dff_LUT), .enab_dff_sign(enab_dff_sign)
`ifdef CORDIC_FSM_STATE_DBG_EN
        , .state_dbg(state_dbg)
`endif
    );

    // Output word: bit order is a bench-local packing, unrelated to the RTL.
    function automatic logic [22:0] dut_word();
        return {enab_dff_sign, enab_dff_LUT, enab_dff_shifted_y, enab_dff_shifted_x,
                enab_d_ff_out, enab_d_ff_Zn, enab_d_ff_Yn, enab_d_ff_Xn,
                enab_RB2, enab_RB1, load_cont_var, enab_cont_var, load_cont_iter,
                enab_cont_iter, mode, sel_mux_2, sel_mux_3, sel_mux_1,
                ack_add_subt, beg_add_subt, ready_CORDIC, reset_reg_cordic};
    endfunction

    function automatic logic [22:0] model_word(int ph, in_t i);
        logic [22:0] e = '0;
        e[5] = i.op ^ i.flag[1] ^ i.flag[0];
        if (!i.rst) begin
            case (ph)
                P_INIT:  begin e[0] = 1; e[13] = 1; e[10] = 1; e[12] = 1; end
                P_LRB2:  begin e[14] = 1; e[4] = !i.mni; end
                P_SHIFT: begin e[19] = 1; e[20] = 1; e[21] = 1; e[22] = 1; end
                P_BEG:   begin e[2] = 1; e[7:6] = i.cv; end
                P_WAIT: begin
                    e[7:6] = i.cv;
                    if (i.rdy) begin
                        e[3] = 1;
                        if (i.cv != 2'b11) e[15 + int'(i.cv)] = 1;
                    end
                end
                P_NEXT:  begin e[11] = 1; e[9] = i.mxv && !i.mxi; end
                P_OUT:   e[18] = 1;
                P_DONE:  e[1] = 1;
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic int model_next(int ph, in_t i);
        if (i.rst) return P_IDLE;
        case (ph)
            P_IDLE:  return i.beg ? P_INIT : P_IDLE;
            P_WAIT:  return i.rdy ? P_NEXT : P_WAIT;
            P_NEXT:  return !i.mxv ? P_BEG : (!i.mxi ? P_LRB2 : P_OUT);
            P_DONE:  return i.ack ? P_IDLE : P_DONE;
            P_OUT:   return P_DONE;
            default: return ph + 1;
        endcase
    endfunction

    task automatic lit(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the inputs just sampled, apply nx, compare mid-cycle.
    task automatic step();
        logic [22:0] exp_w, act_w;
        m_phase = model_next(m_phase, cur);
        @(posedge clk);
        #1;
        cur = nx;
        if (cur.rst) m_phase = P_IDLE;
        @(negedge clk);
        exp_w = model_word(m_phase, cur);
        act_w = dut_word();
        checks++;
        if (act_w !== exp_w) begin
            errors++;
            $display("FAIL cycle_word phase=%0d actual=%h expected=%h t=%0t",
                     m_phase, act_w, exp_w, $time);
        end
`ifdef CORDIC_FSM_STATE_DBG_EN
        lit("state_dbg", state_dbg, cur.rst ? 4'd0 : 4'(m_phase));
`endif
    endtask

    task automatic quiet();
        nx = '{rst: 1'b0, beg: 1'b0, ack: 1'b0, op: 1'b0, flag: 2'b00, cv: 2'b00,
               rdy: 1'b0, mxi: 1'b0, mni: 1'b0, mxv: 1'b0, mnv: 1'b0};
    endtask

    initial begin
        quiet();
        nx.rst = 1'b1;
        cur = nx;
        step();
        step();
        lit("reset_word_zero", 4'(dut_word() != 0), 4'd0);
        quiet();

        // Directed walk-through with hand-derived values.
        nx.beg = 1; step();
        lit("idle_ready", {3'd0, ready_CORDIC}, 4'd0);
        nx.beg = 0; nx.mni = 1; step();
        lit("init_enables", {reset_reg_cordic, enab_RB1, load_cont_iter, load_cont_var}, 4'hF);
        step();
        lit("lrb2_first", {2'd0, enab_RB2, sel_mux_1}, 4'b0010);
        step();
        lit("shift_lut", {enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign}, 4'hF);
        nx.cv = 2'b00; step();
        lit("begin_add_x", {1'b0, beg_add_subt, sel_mux_2}, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            step();
            lit("wait_hold", {2'd0, ack_add_subt, enab_d_ff_Xn}, 4'd0);
        end
        nx.rdy = 1; step();
        lit("ack_x", {ack_add_subt, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn}, 4'b1100);
        nx.rdy = 0; nx.mxv = 0; step();
        lit("next_var", {2'd0, enab_cont_var, enab_cont_iter}, 4'b0010);
        nx.cv = 2'b01; step();
        step();
        nx.rdy = 1; step();
        lit("ack_y", {ack_add_subt, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn}, 4'b1010);
        nx.rdy = 0; nx.mxv = 1; nx.mxi = 0; step();
        lit("next_iter", {2'd0, enab_cont_var, enab_cont_iter}, 4'b0011);
        nx.mxv = 0; nx.mni = 0; step();
        lit("lrb2_later", {2'd0, enab_RB2, sel_mux_1}, 4'b0011);
        step();
        nx.cv = 2'b10; step();
        nx.rdy = 1; step();
        lit("ack_z", {ack_add_subt, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn}, 4'b1001);
        nx.rdy = 0; nx.mxv = 1; nx.mxi = 1; step();
        lit("next_last", {2'd0, enab_cont_var, enab_cont_iter}, 4'b0010);
        nx.mxv = 0; nx.mxi = 0; step();
        lit("output_en", {3'd0, enab_d_ff_out}, 4'd1);
        nx.beg = 1; nx.op = 0; nx.flag = 2'b10; step();
        lit("done_ready", {2'd0, enab_d_ff_out, ready_CORDIC}, 4'b0001);
        lit("sel3_op0_f10", {3'd0, sel_mux_3}, 4'd1);
        nx.op = 1; nx.flag = 2'b01; step();
        lit("done_beg_ignored", {3'd0, ready_CORDIC}, 4'd1);
        lit("sel3_op1_f01", {3'd0, sel_mux_3}, 4'd0);
        nx.beg = 0; nx.ack = 1; nx.op = 0; nx.flag = 2'b00; step();
        lit("done_ack", {3'd0, ready_CORDIC}, 4'd1);
        lit("sel3_op0_f00", {3'd0, sel_mux_3}, 4'd0);
        nx.ack = 0; step();
        lit("back_idle", {3'd0, ready_CORDIC}, 4'd0);

        // Reset in the middle of an adder wait.
        nx.beg = 1; step();
        nx.beg = 0; for (int k = 0; k < 5; k++) step();
        nx.rst = 1; step();
        lit("reset_mid_wait", 4'(dut_word() != 0), 4'd0);
        quiet(); step();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            nx.rst  = ($urandom_range(0, 249) == 0);
            nx.beg  = ($urandom_range(0, 2) == 0);
            nx.ack  = ($urandom_range(0, 2) == 0);
            nx.op   = 1'($urandom);
            nx.flag = 2'($urandom);
            nx.cv   = 2'($urandom);
            nx.rdy  = ($urandom_range(0, 3) == 0);
            nx.mxi  = ($urandom_range(0, 2) == 0);
            nx.mni  = 1'($urandom);
            nx.mxv  = ($urandom_range(0, 2) == 0);
            nx.mnv  = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
